// File: rtl/tb4004_pkg.sv
// Shared TB4004 definitions: machine-cycle phase numbers, opr opcodes and the
// sequencer state encoding used by the cycle sequencer and the instruction decoder.
package tb4004_pkg;

    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    // FIM/SRC share opr 2 and FIN/JIN share opr 3; opa[0] tells them apart.
    localparam logic [3:0] OPR_NOP = 4'h0;
    localparam logic [3:0] OPR_JCN = 4'h1;
    localparam logic [3:0] OPR_FIM = 4'h2;
    localparam logic [3:0] OPR_FIN = 4'h3;
    localparam logic [3:0] OPR_JUN = 4'h4;
    localparam logic [3:0] OPR_JMS = 4'h5;
    localparam logic [3:0] OPR_INC = 4'h6;
    localparam logic [3:0] OPR_ISZ = 4'h7;
    localparam logic [3:0] OPR_ADD = 4'h8;
    localparam logic [3:0] OPR_SUB = 4'h9;
    localparam logic [3:0] OPR_LD  = 4'hA;
    localparam logic [3:0] OPR_XCH = 4'hB;
    localparam logic [3:0] OPR_BBL = 4'hC;
    localparam logic [3:0] OPR_LDM = 4'hD;
    localparam logic [3:0] OPR_IO  = 4'hE;
    localparam logic [3:0] OPR_ACC = 4'hF;

    typedef enum logic [1:0] {
        SEQ_ACTIVE1 = 2'd0,
        SEQ_ACTIVE2 = 2'd1,
        SEQ_HALT    = 2'd2
    } seq_state_e;

    function automatic logic [2:0] nextCycle(input logic [2:0] c);
        return c + 3'd1;
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Classifies an instruction from its first word: whether a second machine
// cycle follows, and whether that second cycle is a FIN register-pair fetch.
module instr_len_decode
    import tb4004_pkg::*;
(
    input  logic [3:0] opr_i,
    input  logic       opaLsb_i,
    output logic       twoWord_o,
    output logic       isFin_o
);

    always_comb begin
        twoWord_o = 1'b0;
        isFin_o   = 1'b0;
        case (opr_i)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: twoWord_o = 1'b1;
            OPR_FIM: twoWord_o = ~opaLsb_i;
            OPR_FIN: begin
                twoWord_o = ~opaLsb_i;
                isFin_o   = ~opaLsb_i;
            end
            default: twoWord_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cycle_sequencer.sv
// TB4004 machine-cycle sequencer: 8-phase cycle counter, opr/opa and second-word
// capture, PC increment strobes, and free-run / halt / single-step control.
module cycle_sequencer
    import tb4004_pkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic       run,
    input  logic       stepReq,
    input  logic [3:0] romData,
    output logic [2:0] cycle,
    output logic       sync,
    output logic [3:0] opr,
    output logic [3:0] opa,
    output logic       secondWord,
    output logic [7:0] operand2,
    output logic       pcInc,
    output logic       addrSel,
    output logic       halted,
    output logic       instDone
);

    seq_state_e stateQ, stateD;
    logic [2:0] cycleQ, cycleD;
    logic [3:0] oprQ, oprD;
    logic [3:0] opaQ, opaD;
    logic [7:0] operand2Q, operand2D;
    logic       bootQ;
    logic       stepPendingQ, stepPendingD;

    logic       syncQ, syncD;
    logic       secondWordQ, secondWordD;
    logic       pcIncQ, pcIncD;
    logic       addrSelQ, addrSelD;
    logic       haltedQ, haltedD;
    logic       instDoneQ, instDoneD;

    logic       twoWordD;
    logic       isFinD;

    // Classification is taken from the next-state opr/opa, so at the M2 edge it
    // already sees the incoming opa nibble.
    instr_len_decode uLenDecode (
        .opr_i    (oprD),
        .opaLsb_i (opaD[0]),
        .twoWord_o(twoWordD),
        .isFin_o  (isFinD)
    );

    always_comb begin
        stateD       = stateQ;
        cycleD       = cycleQ;
        oprD         = oprQ;
        opaD         = opaQ;
        operand2D    = operand2Q;
        stepPendingD = stepPendingQ;

        case (stateQ)
            SEQ_HALT: begin
                cycleD = CYC_A1;
                if (run || stepReq) begin
                    stateD = SEQ_ACTIVE1;
                end
                if (stepReq) begin
                    stepPendingD = 1'b1;
                end
            end

            SEQ_ACTIVE1: begin
                if (cycleQ == CYC_M1) begin
                    oprD = romData;
                end
                if (cycleQ == CYC_M2) begin
                    opaD = romData;
                end
                if (bootQ) begin
                    // The reset state is an instruction boundary: run decides
                    // whether to start counting or park in HALT.
                    if (run) begin
                        cycleD = nextCycle(cycleQ);
                    end else begin
                        stateD = SEQ_HALT;
                    end
                end else if (cycleQ == CYC_X3) begin
                    cycleD = CYC_A1;
                    if (twoWordD) begin
                        stateD = SEQ_ACTIVE2;
                    end else begin
                        stepPendingD = 1'b0;
                        stateD       = run ? SEQ_ACTIVE1 : SEQ_HALT;
                    end
                end else begin
                    cycleD = nextCycle(cycleQ);
                end
            end

            SEQ_ACTIVE2: begin
                if (cycleQ == CYC_M1) begin
                    operand2D[7:4] = romData;
                end
                if (cycleQ == CYC_M2) begin
                    operand2D[3:0] = romData;
                end
                if (cycleQ == CYC_X3) begin
                    cycleD       = CYC_A1;
                    stepPendingD = 1'b0;
                    stateD       = run ? SEQ_ACTIVE1 : SEQ_HALT;
                end else begin
                    cycleD = nextCycle(cycleQ);
                end
            end

            default: begin
                stateD = SEQ_HALT;
                cycleD = CYC_A1;
            end
        endcase
    end

    // Output strobes are computed from the next state so they leave the
    // flops in step with the cycle count they describe.
    always_comb begin
        haltedD     = (stateD == SEQ_HALT);
        secondWordD = (stateD == SEQ_ACTIVE2);
        syncD       = ~haltedD && (cycleD == CYC_X3);
        pcIncD      = (cycleD == CYC_A3) &&
                      ((stateD == SEQ_ACTIVE1) || (secondWordD && ~isFinD));
        addrSelD    = secondWordD && (oprD == OPR_FIN);
        instDoneD   = (cycleD == CYC_X3) &&
                      (secondWordD || ((stateD == SEQ_ACTIVE1) && ~twoWordD));
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateQ       <= SEQ_ACTIVE1;
            cycleQ       <= CYC_A1;
            oprQ         <= OPR_NOP;
            opaQ         <= 4'h0;
            operand2Q    <= 8'h00;
            bootQ        <= 1'b1;
            stepPendingQ <= 1'b0;
            syncQ        <= 1'b0;
            secondWordQ  <= 1'b0;
            pcIncQ       <= 1'b0;
            addrSelQ     <= 1'b0;
            haltedQ      <= 1'b0;
            instDoneQ    <= 1'b0;
        end else begin
            stateQ       <= stateD;
            cycleQ       <= cycleD;
            oprQ         <= oprD;
            opaQ         <= opaD;
            operand2Q    <= operand2D;
            bootQ        <= 1'b0;
            stepPendingQ <= stepPendingD;
            syncQ        <= syncD;
            secondWordQ  <= secondWordD;
            pcIncQ       <= pcIncD;
            addrSelQ     <= addrSelD;
            haltedQ      <= haltedD;
            instDoneQ    <= instDoneD;
        end
    end

    assign cycle      = cycleQ;
    assign sync       = syncQ;
    assign opr        = oprQ;
    assign opa        = opaQ;
    assign secondWord = secondWordQ;
    assign operand2   = operand2Q;
    assign pcInc      = pcIncQ;
    assign addrSel    = addrSelQ;
    assign halted     = haltedQ;
    assign instDone   = instDoneQ;

endmodule
